bpred_table_ctrl: RTL and testbench
===================================

Name: bpred_table_ctrl

Overview:
- Write-port controller for the predictor's combined BTB/bimodal table, 256 entries × 36 bits, with byte enables.
- Runs a zeroing sweep after reset or flush.
- Buffers execute-stage predictor updates in a small in-order FIFO.
- Arbitrates the single table write port between that FIFO and a host/debug write requester.
- All table-side outputs are registered; the block owns the table's write address, data, byte enable and write enable.

Parameters:
INDEX_W, 8, table index width (2^INDEX_W entries)
DATA_W, 36, table entry width
FIFO_DEPTH, 4, update FIFO entries (power of 2)
STARVE_MAX, 3, consecutive lost arbitration cycles after which the host wins

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  restart zeroing sweep; discard queued updates
stall  in  1  pipeline stall; blocks update enqueue
upd_valid  in  1  execute update request
upd_index  in  INDEX_W  update table index
upd_data  in  DATA_W  update entry data
upd_byteen  in  4  update byte enables
upd_ready  out  1  FIFO can accept
host_req  in  1  host write request, level, held until ack
host_index  in  INDEX_W  host index
host_data  in  DATA_W  host data
host_byteen  in  4  host byte enables
host_ack  out  1  one-cycle pulse, host write issued
mem_wren  out  1  table write enable
mem_wraddr  out  INDEX_W  table write address
mem_wdata  out  DATA_W  table write data
mem_byteen  out  4  table byte enables
init_busy  out  1  sweep in progress
fifo_level  out  log2(FIFO_DEPTH)+1  queued update count
drop_count  out  16  saturating count of rejected updates

Behaviour:
- Reset (async) values:
  - State INIT, init_idx=0, FIFO empty, starve=0.
  - mem_wren=0, mem_wraddr=0, mem_wdata=0, mem_byteen=0.
  - host_ack=0, init_busy=1, drop_count=0, upd_ready=0.
- States: INIT and RUN.
- INIT:
  - Each cycle, register a write: mem_wren=1, mem_wraddr=init_idx, mem_wdata=0, mem_byteen=4'hF; then init_idx++.
  - The write to index 2^INDEX_W-1 is the last. Next state RUN, so the sweep takes exactly 256 write cycles.
  - init_busy falls in the first RUN cycle.
  - upd_ready=0. The host is never granted; host_req stays pending.
- flush (any state): next cycle INIT, init_idx=0, FIFO emptied, starve=0. Discarded entries are not counted as drops. flush during INIT restarts the sweep from 0.
- upd_ready = (state==RUN) & (fifo_level<FIFO_DEPTH) & ~flush. Combinational from registered state.
- Enqueue when upd_valid & upd_ready & ~stall.
- Drop when upd_valid & ~stall & ~upd_ready: drop_count increments, saturating at 16'hFFFF. Updates presented while stall is high are ignored and not counted.
- Simultaneous enqueue and dequeue: fifo_level is unchanged. A full FIFO does not accept, even if it is dequeuing in the same cycle.
- RUN arbitration, evaluated each cycle; one write is issued at most per cycle:
  - Host eligible = host_req & ~host_ack, which prevents a double grant while the requester drops its request.
  - FIFO wins if non-empty, unless host is eligible and starve==STARVE_MAX; then host wins.
  - starve increments when host is eligible and loses. It clears on a host grant or when host is not eligible.
  - With the FIFO empty, an eligible host wins immediately.
- Write latency: a grant in cycle t drives mem_wren/addr/data/byteen with the winner's fields in cycle t+1.
  - A host grant also pulses host_ack in t+1.
  - A FIFO grant pops the head at the t edge.
  - mem_wren=0 in RUN cycles with no grant.
- Ordering:
  - FIFO writes issue strictly in arrival order.
  - There is no hazard check between host and FIFO writes to the same index; the later write wins.
- fifo_level wraps only through pointer arithmetic of width log2(FIFO_DEPTH)+1 and never exceeds FIFO_DEPTH.

Test Plan:
- Release reset → 256 consecutive mem_wren cycles, addr 0x00..0xFF ascending, data 0, byteen 4'hF; init_busy=0 and upd_ready=1 the following cycle.
- RUN, idle; upd_valid one cycle with index 0x12, data 36'h123456789, byteen 4'h1 → exactly one mem_wren cycle one clock later with identical fields; fifo_level back to 0.
- host_req held while upd_valid streams every cycle → FIFO wins 3 consecutive grants, then a host write with host_ack single pulse, then the FIFO resumes; no update lost or reordered.
- upd_valid high for 10 cycles during the INIT sweep with stall=0 → drop_count=10, no extra writes. Repeat with stall=1 → drop_count unchanged.
- Two updates queued (host winning), then flush → queued entries never written, sweep restarts at addr 0, drop_count unchanged.
- Assert reset asynchronously mid-sweep at index 100 → mem_wren=0 and init_busy=1 immediately without waiting for a clock edge; after release the sweep restarts at 0.

Source files
------------

// File: rtl/bpred_table_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bpred_table_ctrl_if
// Purpose  : Bundles the request, update, host and table-write signals of the
//            branch-predictor table write-port controller.
// Modports : master - requester side (drives flush/stall/updates/host writes,
//                     observes the table write port and status)
//            slave  - controller side (bpred_table_ctrl)
// Revision : 1.0 - initial release
// ============================================================================
interface bpred_table_ctrl_if #(
    parameter int INDEX_W    = 8,
    parameter int DATA_W     = 36,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

    // Pipeline control
    logic               flush;
    logic               stall;

    // Execute-stage update requests
    logic               upd_valid;
    logic [INDEX_W-1:0] upd_index;
    logic [DATA_W-1:0]  upd_data;
    logic [3:0]         upd_byteen;
    logic               upd_ready;

    // Host / debug write requests
    logic               host_req;
    logic [INDEX_W-1:0] host_index;
    logic [DATA_W-1:0]  host_data;
    logic [3:0]         host_byteen;
    logic               host_ack;

    // Table write port
    logic               mem_wren;
    logic [INDEX_W-1:0] mem_wraddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [3:0]         mem_byteen;

    // Status
    logic               init_busy;
    logic [c_lvl_w-1:0] fifo_level;
    logic [15:0]        drop_count;

    modport master (
        output flush, stall,
        output upd_valid, upd_index, upd_data, upd_byteen,
        output host_req, host_index, host_data, host_byteen,
        input  upd_ready, host_ack,
        input  mem_wren, mem_wraddr, mem_wdata, mem_byteen,
        input  init_busy, fifo_level, drop_count
    );

    modport slave (
        input  flush, stall,
        input  upd_valid, upd_index, upd_data, upd_byteen,
        input  host_req, host_index, host_data, host_byteen,
        output upd_ready, host_ack,
        output mem_wren, mem_wraddr, mem_wdata, mem_byteen,
        output init_busy, fifo_level, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/bpred_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bpred_table_ctrl
// Purpose  : Write-port controller for the combined BTB/bimodal predictor
//            table. Zeroes the whole table after reset or flush, queues
//            execute-stage updates in an in-order FIFO and arbitrates the
//            single write port between that FIFO and a host/debug requester
//            (FIFO priority with a starvation limit for the host).
// Ports    : clk, reset (async, active-high)
//            bus (bpred_table_ctrl_if.slave): flush/stall, update request
//            channel, host request channel, registered table write port,
//            init_busy / fifo_level / drop_count status
// Revision : 1.0 - initial release
// ============================================================================
module bpred_table_ctrl #(
    parameter int INDEX_W    = 8,
    parameter int DATA_W     = 36,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  wire logic         clk,
    input  wire logic         reset,
    bpred_table_ctrl_if.slave bus
);
    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_stv_w = $clog2(STARVE_MAX + 1);
    localparam int c_ent_w = INDEX_W + DATA_W + 4;
    localparam logic [c_lvl_w-1:0] c_depth      = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_stv_w-1:0] c_starve_max = c_stv_w'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [INDEX_W-1:0] r_init_idx;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_lvl_w-1:0] r_wr_ptr;
    logic [c_lvl_w-1:0] r_rd_ptr;
    logic [c_ent_w-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [c_stv_w-1:0] r_starve;
    logic               r_mem_wren;
    logic [INDEX_W-1:0] r_mem_wraddr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [3:0]         r_mem_byteen;
    logic               r_host_ack;
    logic [15:0]        r_drop_count;

    logic [c_lvl_w-1:0] w_level;
    logic               w_upd_ready;
    logic               w_enq;
    logic               w_drop;
    logic               w_fifo_ne;
    logic               w_host_elig;
    logic               w_arb_en;
    logic               w_host_win;
    logic               w_fifo_win;
    logic [c_ent_w-1:0] w_head;

    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign w_upd_ready = (r_state == ST_RUN) && (w_level < c_depth) && !bus.flush;
    assign w_enq       = bus.upd_valid & w_upd_ready & ~bus.stall;
    assign w_drop      = bus.upd_valid & ~bus.stall & ~w_upd_ready;
    assign w_fifo_ne   = (w_level != '0);

    // A host whose ack is on the wire this cycle is still holding its request
    // level; masking it here keeps one request from being granted twice.
    assign w_host_elig = bus.host_req & ~r_host_ack;
    assign w_arb_en    = (r_state == ST_RUN) & ~bus.flush;
    assign w_host_win  = w_arb_en & w_host_elig &
                         (~w_fifo_ne | (r_starve == c_starve_max));
    assign w_fifo_win  = w_arb_en & w_fifo_ne & ~w_host_win;
    assign w_head      = r_fifo_mem[r_rd_ptr[c_ptr_w-1:0]];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_mem[r_wr_ptr[c_ptr_w-1:0]] <= {bus.upd_index, bus.upd_data, bus.upd_byteen};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_init_idx   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_starve     <= '0;
            r_mem_wren   <= 1'b0;
            r_mem_wraddr <= '0;
            r_mem_wdata  <= '0;
            r_mem_byteen <= 4'h0;
            r_host_ack   <= 1'b0;
            r_drop_count <= 16'h0000;
        end else begin
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end

            if (bus.flush) begin
                // Queued updates are discarded silently; they are not drops.
                r_state    <= ST_INIT;
                r_init_idx <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_starve   <= '0;
                r_mem_wren <= 1'b0;
                r_host_ack <= 1'b0;
            end else begin
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_fifo_win) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_host_ack <= w_host_win;

                if (r_state == ST_INIT) begin
                    r_mem_wren   <= 1'b1;
                    r_mem_wraddr <= r_init_idx;
                    r_mem_wdata  <= '0;
                    r_mem_byteen <= 4'hF;
                    r_init_idx   <= r_init_idx + 1'b1;
                    r_starve     <= '0;
                    if (r_init_idx == '1) begin
                        r_state <= ST_RUN;
                    end
                end else if (w_host_win) begin
                    r_mem_wren   <= 1'b1;
                    r_mem_wraddr <= bus.host_index;
                    r_mem_wdata  <= bus.host_data;
                    r_mem_byteen <= bus.host_byteen;
                    r_starve     <= '0;
                end else if (w_fifo_win) begin
                    r_mem_wren   <= 1'b1;
                    r_mem_wraddr <= w_head[c_ent_w-1 -: INDEX_W];
                    r_mem_wdata  <= w_head[DATA_W+3:4];
                    r_mem_byteen <= w_head[3:0];
                    // Only an eligible host that lost accumulates starvation.
                    r_starve     <= w_host_elig ? (r_starve + 1'b1) : '0;
                end else begin
                    r_mem_wren <= 1'b0;
                    r_starve   <= '0;
                end
            end
        end
    end

    assign bus.upd_ready  = w_upd_ready;
    assign bus.host_ack   = r_host_ack;
    assign bus.mem_wren   = r_mem_wren;
    assign bus.mem_wraddr = r_mem_wraddr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_byteen = r_mem_byteen;
    assign bus.init_busy  = (r_state == ST_INIT);
    assign bus.fifo_level = w_level;
    assign bus.drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_bpred_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpred_table_ctrl
// Purpose  : Directed self-checking bench for bpred_table_ctrl: reset sweep,
//            single update, FIFO/host starvation arbitration, drops during
//            the sweep (with and without stall), flush of queued updates and
//            an asynchronous reset in the middle of a sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpred_table_ctrl;
    localparam int INDEX_W    = 8;
    localparam int DATA_W     = 36;
    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_MAX = 3;
    localparam logic [47:0] c_host_entry = {8'hA0, 36'hABCDEF012, 4'h6};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bpred_table_ctrl_if #(.INDEX_W(INDEX_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    bpred_table_ctrl #(
        .INDEX_W   (INDEX_W),
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [47:0] wlog[$];
    int          ack_cnt  = 0;
    int          log_base;
    int          ack_base;
    logic [47:0] exp_e;
    logic [47:0] obs_e;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_wren) wlog.push_back({bus.mem_wraddr, bus.mem_wdata, bus.mem_byteen});
            if (bus.host_ack) ack_cnt++;
        end
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] upd_entry(input int base, input int c);
        logic [7:0]  a;
        logic [35:0] d;
        logic [3:0]  b;
        a = 8'(base + c);
        d = 36'(base * 256 + c);
        b = 4'(c + 1);
        return {a, d, b};
    endfunction

    function automatic logic [47:0] log_at(input int idx);
        return (idx < wlog.size()) ? wlog[idx] : 48'hFFFF_FFFF_FFFF;
    endfunction

    // Number of logged writes in [start, start+n) that are not the zeroing
    // write for index k.
    function automatic int sweep_bad(input int start, input int n);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if (log_at(start + k) !== {8'(k), 36'h0, 4'hF}) bad++;
        end
        return bad;
    endfunction

    task automatic drive_upd(input logic v, input logic [47:0] e);
        bus.upd_valid  = v;
        bus.upd_index  = e[47:40];
        bus.upd_data   = e[39:4];
        bus.upd_byteen = e[3:0];
    endtask

    // Streams n_upd updates (one per cycle) while the host raises its request
    // from cycle 1 until acked. With do_flush, flush is issued on the cycle
    // after the ack is seen, while two updates are still queued.
    task automatic stream_with_host(input int base, input int n_upd, input int n_cycles,
                                    input logic do_flush);
        logic ack_seen;
        ack_seen = 1'b0;
        for (int c = 0; c < n_cycles; c++) begin
            if (do_flush && ack_seen) begin
                check_value("level_before_flush", 64'(bus.fifo_level), 64'd2);
                drive_upd(1'b0, 48'h0);
                bus.host_req = 1'b0;
                bus.flush    = 1'b1;
                tick();
                bus.flush = 1'b0;
                check_value("flush_wren", 64'(bus.mem_wren), 64'd0);
                check_value("flush_level", 64'(bus.fifo_level), 64'd0);
                check_value("flush_busy", 64'(bus.init_busy), 64'd1);
                return;
            end
            drive_upd(c < n_upd, upd_entry(base, c));
            bus.host_req = (c >= 1) && !ack_seen;
            tick();
            if (bus.host_ack) ack_seen = 1'b1;
        end
        bus.host_req = 1'b0;
        drive_upd(1'b0, 48'h0);
    endtask

    initial begin
        bus.flush       = 1'b0;
        bus.stall       = 1'b0;
        drive_upd(1'b0, 48'h0);
        bus.host_req    = 1'b0;
        bus.host_index  = c_host_entry[47:40];
        bus.host_data   = c_host_entry[39:4];
        bus.host_byteen = c_host_entry[3:0];

        // ---- Reset state ----
        #2 reset = 1'b1;
        #1;
        check_value("rst_wren", 64'(bus.mem_wren), 64'd0);
        check_value("rst_addr_data_be", {bus.mem_wraddr, bus.mem_wdata, bus.mem_byteen}, 64'd0);
        check_value("rst_busy", 64'(bus.init_busy), 64'd1);
        check_value("rst_ready", 64'(bus.upd_ready), 64'd0);
        check_value("rst_ack", 64'(bus.host_ack), 64'd0);
        check_value("rst_drop", 64'(bus.drop_count), 64'd0);
        check_value("rst_level", 64'(bus.fifo_level), 64'd0);

        // ---- Sweep after reset release ----
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tick();
            check_value("sweep_write", {bus.mem_wren, bus.mem_wraddr, bus.mem_wdata, bus.mem_byteen},
                        {1'b1, 8'(i), 36'h0, 4'hF});
            if (i == 254) check_value("sweep_busy_late", 64'(bus.init_busy), 64'd1);
            if (i == 255) check_value("sweep_busy_fall", 64'(bus.init_busy), 64'd0);
        end
        tick();
        check_value("post_sweep_wren", 64'(bus.mem_wren), 64'd0);
        check_value("post_sweep_busy", 64'(bus.init_busy), 64'd0);
        check_value("post_sweep_ready", 64'(bus.upd_ready), 64'd1);

        // ---- Single update ----
        log_base = wlog.size();
        drive_upd(1'b1, {8'h12, 36'h123456789, 4'h1});
        check_value("single_ready", 64'(bus.upd_ready), 64'd1);
        tick();
        drive_upd(1'b0, 48'h0);
        check_value("single_level_q", 64'(bus.fifo_level), 64'd1);
        check_value("single_wren_early", 64'(bus.mem_wren), 64'd0);
        tick();
        check_value("single_write", {bus.mem_wren, bus.mem_wraddr, bus.mem_wdata, bus.mem_byteen},
                    {1'b1, 8'h12, 36'h123456789, 4'h1});
        check_value("single_level_done", 64'(bus.fifo_level), 64'd0);
        tick();
        check_value("single_wren_off", 64'(bus.mem_wren), 64'd0);
        tick();
        check_value("single_count", 64'(wlog.size() - log_base), 64'd1);

        // ---- FIFO vs host starvation arbitration ----
        log_base = wlog.size();
        ack_base = ack_cnt;
        stream_with_host(32'h20, 8, 14, 1'b0);
        tick();
        tick();
        check_value("arb_count", 64'(wlog.size() - log_base), 64'd9);
        for (int k = 0; k < 9; k++) begin
            if (k < 3)       exp_e = upd_entry(32'h20, k);
            else if (k == 3) exp_e = c_host_entry;
            else             exp_e = upd_entry(32'h20, k - 1);
            obs_e = log_at(log_base + k);
            check_value("arb_order", obs_e, exp_e);
        end
        check_value("arb_ack_pulses", 64'(ack_cnt - ack_base), 64'd1);
        check_value("arb_level", 64'(bus.fifo_level), 64'd0);
        check_value("arb_drop", 64'(bus.drop_count), 64'd0);

        // ---- Drops during the sweep, then stalled updates ignored ----
        log_base   = wlog.size();
        bus.flush  = 1'b1;
        tick();
        bus.flush  = 1'b0;
        check_value("flush_busy_run", 64'(bus.init_busy), 64'd1);
        for (int i = 0; i < 10; i++) begin
            drive_upd(1'b1, upd_entry(32'h60, i));
            tick();
        end
        drive_upd(1'b0, 48'h0);
        check_value("drop_ten", 64'(bus.drop_count), 64'd10);
        bus.stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_upd(1'b1, upd_entry(32'h70, i));
            tick();
        end
        drive_upd(1'b0, 48'h0);
        bus.stall = 1'b0;
        check_value("drop_stalled", 64'(bus.drop_count), 64'd10);
        for (int n = 0; n < 300 && bus.init_busy; n++) tick();
        check_value("sweep2_timeout", 64'(bus.init_busy), 64'd0);
        tick();
        check_value("sweep2_count", 64'(wlog.size() - log_base), 64'd256);
        check_value("sweep2_bad", 64'(sweep_bad(log_base, 256)), 64'd0);

        // ---- Flush with two queued updates ----
        log_base = wlog.size();
        ack_base = ack_cnt;
        stream_with_host(32'h40, 8, 14, 1'b1);
        check_value("flush_drop_kept", 64'(bus.drop_count), 64'd10);
        for (int n = 0; n < 300 && !(bus.mem_wren && bus.mem_wraddr == 8'd100); n++) tick();
        check_value("reach_idx100", {bus.mem_wren, bus.mem_wraddr}, {1'b1, 8'd100});

        // ---- Asynchronous reset mid-sweep ----
        #2 reset = 1'b1;
        #1;
        check_value("areset_wren", 64'(bus.mem_wren), 64'd0);
        check_value("areset_busy", 64'(bus.init_busy), 64'd1);
        check_value("areset_drop", 64'(bus.drop_count), 64'd0);
        check_value("areset_ready", 64'(bus.upd_ready), 64'd0);
        check_value("flush_log_count", 64'(wlog.size() - log_base), 64'd104);
        for (int k = 0; k < 4; k++) begin
            exp_e = (k == 3) ? c_host_entry : upd_entry(32'h40, k);
            obs_e = log_at(log_base + k);
            check_value("flush_pre_order", obs_e, exp_e);
        end
        check_value("flush_ack_pulses", 64'(ack_cnt - ack_base), 64'd1);
        check_value("flush_sweep_restart", 64'(sweep_bad(log_base + 4, 100)), 64'd0);

        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        log_base = wlog.size();
        for (int i = 0; i < 258; i++) tick();
        check_value("sweep3_count", 64'(wlog.size() - log_base), 64'd256);
        check_value("sweep3_bad", 64'(sweep_bad(log_base, 256)), 64'd0);
        check_value("sweep3_busy", 64'(bus.init_busy), 64'd0);
        check_value("sweep3_ready", 64'(bus.upd_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
